// File: rtl/npc_bpred_pkg.sv
// Shared definitions for the next-PC predictor: npc_op encodings,
// 2-bit saturating counter states and the counter step function.
package npc_bpred_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        NPC_SEL_PC4    = 2'd0,
        NPC_SEL_OFFSET = 2'd1,
        NPC_SEL_BRANCH = 2'd2,
        NPC_SEL_ABS    = 2'd3
    } npc_sel_e;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bht_cnt_e;

    // New entries start weakly taken so one not-taken outcome flips them.
    localparam logic [1:0] CNT_ALLOC = WT;

    function automatic logic [1:0] cnt_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = cur + 2'd1;
        end else begin
            if (cur != SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer with per-entry 2-bit direction counters.
// One combinational lookup port, one registered update port.
//
// counter state | meaning
// SNT           | strongly not taken
// WNT           | weakly not taken
// WT            | weakly taken (allocation value)
// ST            | strongly taken
module npc_btb
    import npc_bpred_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-3:0] lookup_word,
    output logic            lookup_taken,
    output logic [XLEN-1:0] lookup_target,
    input  logic            upd_en,
    input  logic [XLEN-3:0] upd_word,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    logic [BTB_DEPTH-1:0] valid;
    logic [TAG_W-1:0]     tag_mem    [BTB_DEPTH];
    logic [XLEN-1:0]      target_mem [BTB_DEPTH];
    logic [1:0]           cnt_mem    [BTB_DEPTH];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    assign lk_idx = lookup_word[IDX_W-1:0];
    assign lk_tag = lookup_word[XLEN-3:IDX_W];
    assign up_idx = upd_word[IDX_W-1:0];
    assign up_tag = upd_word[XLEN-3:IDX_W];

    // Lookup reads the arrays directly, so a same-cycle update is not visible.
    assign lk_hit        = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign lookup_taken  = lk_hit && cnt_mem[lk_idx][1];
    assign lookup_target = target_mem[lk_idx];

    assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (upd_en && !up_hit && upd_taken) begin
            valid[up_idx] <= 1'b1;
        end
    end

    // Payload is not reset; an entry is invisible until its valid bit is set.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            if (up_hit) begin
                cnt_mem[up_idx] <= cnt_next(cnt_mem[up_idx], upd_taken);
                if (upd_taken) begin
                    target_mem[up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                tag_mem[up_idx]    <= up_tag;
                target_mem[up_idx] <= upd_target;
                cnt_mem[up_idx]    <= CNT_ALLOC;
            end
        end
    end

endmodule

// File: rtl/npc_bpred.sv
// Next-PC unit: fetch PC register, BTB-based prediction, EX-stage resolution
// with redirect on misprediction, and control-flow performance counters.
module npc_bpred
    import npc_bpred_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BTB_DEPTH = 16,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic [1:0]       ex_npc_op,
    input  logic             ex_br,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_sext,
    input  logic [XLEN-1:0]  ex_alu_c,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc4,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] ctrl_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic            btb_taken;
    logic [XLEN-1:0] btb_target;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] ex_pc4;
    logic            upd_en;

    assign pc4         = pc + XLEN'(4);
    assign pred_taken  = btb_taken;
    assign pred_target = btb_taken ? btb_target : pc4;

    assign ex_pc4 = ex_pc + XLEN'(4);
    assign upd_en = ex_valid && (ex_npc_op != NPC_SEL_PC4);

    always_comb begin
        res_taken  = 1'b0;
        res_target = '0;
        case (ex_npc_op)
            NPC_SEL_PC4: begin
                res_taken  = 1'b0;
                res_target = '0;
            end
            NPC_SEL_OFFSET: begin
                res_taken  = 1'b1;
                res_target = ex_pc + ex_sext;
            end
            NPC_SEL_BRANCH: begin
                res_taken  = ex_br;
                res_target = ex_pc + ex_sext;
            end
            NPC_SEL_ABS: begin
                res_taken  = 1'b1;
                res_target = ex_alu_c;
            end
        endcase
    end

    // A correctly predicted not-taken instruction never compares targets.
    assign redirect    = ex_valid && ((res_taken != ex_pred_taken) ||
                                      (res_taken && (res_target != ex_pred_target)));
    assign redirect_pc = res_taken ? res_target : ex_pc4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (!stall) begin
            pc <= pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_cnt    <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd_en)   ctrl_cnt    <= ctrl_cnt + CNT_W'(1);
            if (redirect) mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

    npc_btb #(
        .XLEN      (XLEN),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_word   (pc[XLEN-1:2]),
        .lookup_taken  (btb_taken),
        .lookup_target (btb_target),
        .upd_en        (upd_en),
        .upd_word      (ex_pc[XLEN-1:2]),
        .upd_taken     (res_taken),
        .upd_target    (res_target)
    );

endmodule

// File: tb/tb_npc_bpred.sv
// Directed self-checking bench for npc_bpred with hand-computed expectations.
module tb_npc_bpred;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic [1:0]  ex_npc_op;
    logic        ex_br;
    logic [31:0] ex_pc;
    logic [31:0] ex_sext;
    logic [31:0] ex_alu_c;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ctrl_cnt;
    logic [31:0] mispred_cnt;

    int n_pass   = 0;
    int n_total  = 0;
    int exp_ctrl = 0;
    int exp_mis  = 0;

    always #5 clk = ~clk;

    npc_bpred dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .ex_npc_op      (ex_npc_op),
        .ex_br          (ex_br),
        .ex_pc          (ex_pc),
        .ex_sext        (ex_sext),
        .ex_alu_c       (ex_alu_c),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .pc             (pc),
        .pc4            (pc4),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .ctrl_cnt       (ctrl_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    task automatic drive_ex(input logic [1:0] op, input logic br, input logic [31:0] epc,
                            input logic [31:0] sext, input logic [31:0] aluc,
                            input logic pt, input logic [31:0] ptg);
        ex_valid       = 1'b1;
        ex_npc_op      = op;
        ex_br          = br;
        ex_pc          = epc;
        ex_sext        = sext;
        ex_alu_c       = aluc;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
        if (op != 2'd0) exp_ctrl++;
    endtask

    task automatic clear_ex();
        ex_valid       = 1'b0;
        ex_npc_op      = 2'd0;
        ex_br          = 1'b0;
        ex_pc          = '0;
        ex_sext        = '0;
        ex_alu_c       = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
    endtask

    // Steer fetch to addr via a mispredicted plain instruction at addr-4 (no BTB update).
    task automatic jump_to(input logic [31:0] addr);
        @(negedge clk);
        drive_ex(2'd0, 1'b0, addr - 32'd4, '0, '0, 1'b1, 32'h0);
        exp_mis++;
        @(posedge clk);
        #1 clear_ex();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        clear_ex();
        repeat (3) @(negedge clk);
        n_total++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else n_pass++;
        n_total++; if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken: got %b want 0", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h4) $display("FAIL reset_pred_target: got %h want %h", pred_target, 32'h4); else n_pass++;
        n_total++; if (ctrl_cnt !== 32'h0) $display("FAIL reset_ctrl_cnt: got %0d want 0", ctrl_cnt); else n_pass++;
        n_total++; if (mispred_cnt !== 32'h0) $display("FAIL reset_mispred_cnt: got %0d want 0", mispred_cnt); else n_pass++;
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_total++; if (pc !== 32'(4 * i)) $display("FAIL seq_pc%0d: got %h want %h", i, pc, 32'(4 * i)); else n_pass++;
            n_total++; if (redirect !== 1'b0) $display("FAIL seq_redirect%0d: got %b want 0", i, redirect); else n_pass++;
        end
    endtask

    task automatic test_branch_alloc();
        @(negedge clk);
        drive_ex(2'd2, 1'b1, 32'h10, 32'h20, '0, 1'b0, 32'h14);
        exp_mis++;
        #1;
        n_total++; if (redirect !== 1'b1) $display("FAIL alloc_redirect: got %b want 1", redirect); else n_pass++;
        n_total++; if (redirect_pc !== 32'h30) $display("FAIL alloc_redirect_pc: got %h want %h", redirect_pc, 32'h30); else n_pass++;
        @(posedge clk);
        #1 clear_ex();
        @(negedge clk);
        n_total++; if (pc !== 32'h30) $display("FAIL alloc_next_pc: got %h want %h", pc, 32'h30); else n_pass++;
        n_total++; if (mispred_cnt !== 32'd1) $display("FAIL alloc_mispred_cnt: got %0d want 1", mispred_cnt); else n_pass++;
        n_total++; if (ctrl_cnt !== 32'd1) $display("FAIL alloc_ctrl_cnt: got %0d want 1", ctrl_cnt); else n_pass++;
        jump_to(32'h10);
        @(negedge clk);
        n_total++; if (pc !== 32'h10) $display("FAIL refetch_pc: got %h want %h", pc, 32'h10); else n_pass++;
        n_total++; if (pred_taken !== 1'b1) $display("FAIL refetch_pred_taken: got %b want 1", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h30) $display("FAIL refetch_pred_target: got %h want %h", pred_target, 32'h30); else n_pass++;
        @(negedge clk);
        n_total++; if (pc !== 32'h30) $display("FAIL follow_pred_pc: got %h want %h", pc, 32'h30); else n_pass++;
    endtask

    task automatic test_counter_decay();
        // counter WT -> WNT
        @(negedge clk);
        drive_ex(2'd2, 1'b0, 32'h10, 32'h20, '0, 1'b1, 32'h30);
        exp_mis++;
        #1;
        n_total++; if (redirect !== 1'b1) $display("FAIL nt1_redirect: got %b want 1", redirect); else n_pass++;
        n_total++; if (redirect_pc !== 32'h14) $display("FAIL nt1_redirect_pc: got %h want %h", redirect_pc, 32'h14); else n_pass++;
        @(posedge clk);
        #1 clear_ex();
        jump_to(32'h10);
        @(negedge clk);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL nt1_pred_taken: got %b want 0", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h14) $display("FAIL nt1_pred_target: got %h want %h", pred_target, 32'h14); else n_pass++;
        // counter WNT -> SNT
        drive_ex(2'd2, 1'b0, 32'h10, 32'h20, '0, 1'b1, 32'h30);
        exp_mis++;
        #1;
        n_total++; if (redirect_pc !== 32'h14) $display("FAIL nt2_redirect_pc: got %h want %h", redirect_pc, 32'h14); else n_pass++;
        @(posedge clk);
        #1 clear_ex();
        // correctly predicted not-taken: no redirect, counter saturates at SNT
        @(negedge clk);
        drive_ex(2'd2, 1'b0, 32'h10, 32'h20, '0, 1'b0, 32'h14);
        #1;
        n_total++; if (redirect !== 1'b0) $display("FAIL nt3_redirect: got %b want 0", redirect); else n_pass++;
        @(posedge clk);
        #1 clear_ex();
        // one taken: SNT -> WNT, still predicts not taken
        @(negedge clk);
        drive_ex(2'd2, 1'b1, 32'h10, 32'h20, '0, 1'b0, 32'h14);
        exp_mis++;
        #1;
        n_total++; if (redirect_pc !== 32'h30) $display("FAIL t_after_snt_redirect_pc: got %h want %h", redirect_pc, 32'h30); else n_pass++;
        @(posedge clk);
        #1 clear_ex();
        jump_to(32'h10);
        @(negedge clk);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL sat_low_pred_taken: got %b want 0", pred_taken); else n_pass++;
    endtask

    task automatic test_counter_sat();
        // WNT -> WT (mispredicted), then WT -> ST -> ST (predicted)
        @(negedge clk);
        drive_ex(2'd2, 1'b1, 32'h10, 32'h20, '0, 1'b0, 32'h14);
        exp_mis++;
        @(posedge clk);
        #1 clear_ex();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_ex(2'd2, 1'b1, 32'h10, 32'h20, '0, 1'b1, 32'h30);
            #1;
            n_total++; if (redirect !== 1'b0) $display("FAIL sat_taken%0d_redirect: got %b want 0", k, redirect); else n_pass++;
            @(posedge clk);
            #1 clear_ex();
        end
        // ST -> WT, still predicts taken
        @(negedge clk);
        drive_ex(2'd2, 1'b0, 32'h10, 32'h20, '0, 1'b1, 32'h30);
        exp_mis++;
        #1;
        n_total++; if (redirect !== 1'b1) $display("FAIL sat_nt_redirect: got %b want 1", redirect); else n_pass++;
        @(posedge clk);
        #1 clear_ex();
        jump_to(32'h10);
        @(negedge clk);
        n_total++; if (pred_taken !== 1'b1) $display("FAIL sat_high_pred_taken: got %b want 1", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h30) $display("FAIL sat_high_pred_target: got %h want %h", pred_target, 32'h30); else n_pass++;
    endtask

    task automatic test_abs_target();
        @(negedge clk);
        drive_ex(2'd3, 1'b0, 32'h40, '0, 32'h80, 1'b0, 32'h44);
        exp_mis++;
        #1;
        n_total++; if (redirect_pc !== 32'h80) $display("FAIL abs_alloc_redirect_pc: got %h want %h", redirect_pc, 32'h80); else n_pass++;
        @(posedge clk);
        #1 clear_ex();
        jump_to(32'h40);
        @(negedge clk);
        n_total++; if (pred_target !== 32'h80) $display("FAIL abs_pred_target_old: got %h want %h", pred_target, 32'h80); else n_pass++;
        drive_ex(2'd3, 1'b0, 32'h40, '0, 32'h100, 1'b1, 32'h80);
        exp_mis++;
        #1;
        n_total++; if (redirect !== 1'b1) $display("FAIL abs_mismatch_redirect: got %b want 1", redirect); else n_pass++;
        n_total++; if (redirect_pc !== 32'h100) $display("FAIL abs_mismatch_redirect_pc: got %h want %h", redirect_pc, 32'h100); else n_pass++;
        @(posedge clk);
        #1 clear_ex();
        @(negedge clk);
        n_total++; if (pc !== 32'h100) $display("FAIL abs_next_pc: got %h want %h", pc, 32'h100); else n_pass++;
        jump_to(32'h40);
        @(negedge clk);
        n_total++; if (pred_target !== 32'h100) $display("FAIL abs_pred_target_new: got %h want %h", pred_target, 32'h100); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] held;
        @(negedge clk);
        stall = 1'b1;
        held  = pc;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++; if (pc !== held) $display("FAIL stall_hold%0d: got %h want %h", k, pc, held); else n_pass++;
        end
        drive_ex(2'd1, 1'b0, 32'h200, 32'h40, '0, 1'b0, 32'h204);
        exp_mis++;
        @(posedge clk);
        #1 clear_ex();
        @(negedge clk);
        n_total++; if (pc !== 32'h240) $display("FAIL stall_redirect_pc: got %h want %h", pc, 32'h240); else n_pass++;
        @(negedge clk);
        n_total++; if (pc !== 32'h240) $display("FAIL stall_after_redirect: got %h want %h", pc, 32'h240); else n_pass++;
        stall = 1'b0;
        @(negedge clk);
        n_total++; if (pc !== 32'h244) $display("FAIL unstall_pc: got %h want %h", pc, 32'h244); else n_pass++;
    endtask

    task automatic test_alias();
        @(negedge clk);
        drive_ex(2'd2, 1'b1, 32'h50, 32'h10, '0, 1'b0, 32'h54);
        exp_mis++;
        #1;
        n_total++; if (redirect_pc !== 32'h60) $display("FAIL alias_redirect_pc: got %h want %h", redirect_pc, 32'h60); else n_pass++;
        @(posedge clk);
        #1 clear_ex();
        jump_to(32'h10);
        @(negedge clk);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL alias_old_pred_taken: got %b want 0", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h14) $display("FAIL alias_old_pred_target: got %h want %h", pred_target, 32'h14); else n_pass++;
        jump_to(32'h50);
        @(negedge clk);
        n_total++; if (pred_taken !== 1'b1) $display("FAIL alias_new_pred_taken: got %b want 1", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h60) $display("FAIL alias_new_pred_target: got %h want %h", pred_target, 32'h60); else n_pass++;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        drive_ex(2'd1, 1'b0, 32'hFFFF_FFFC, 32'h8, '0, 1'b0, 32'h0);
        exp_mis++;
        #1;
        n_total++; if (redirect_pc !== 32'h4) $display("FAIL wrap_redirect_pc: got %h want %h", redirect_pc, 32'h4); else n_pass++;
        @(posedge clk);
        #1 clear_ex();
        jump_to(32'hFFFF_FFFC);
        @(negedge clk);
        n_total++; if (pc4 !== 32'h0) $display("FAIL wrap_pc4: got %h want %h", pc4, 32'h0); else n_pass++;
        n_total++; if (pred_target !== 32'h4) $display("FAIL wrap_pred_target: got %h want %h", pred_target, 32'h4); else n_pass++;
    endtask

    task automatic test_counters();
        @(negedge clk);
        n_total++; if (ctrl_cnt !== 32'(exp_ctrl)) $display("FAIL ctrl_cnt: got %0d want %0d", ctrl_cnt, exp_ctrl); else n_pass++;
        n_total++; if (mispred_cnt !== 32'(exp_mis)) $display("FAIL mispred_cnt: got %0d want %0d", mispred_cnt, exp_mis); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_ex(2'd1, 1'b0, 32'h80, 32'h40, '0, 1'b0, 32'h84);
        rst_n = 1'b0;
        #1;
        n_total++; if (pc !== 32'h0) $display("FAIL midrst_pc: got %h want %h", pc, 32'h0); else n_pass++;
        n_total++; if (ctrl_cnt !== 32'h0) $display("FAIL midrst_ctrl_cnt: got %0d want 0", ctrl_cnt); else n_pass++;
        n_total++; if (mispred_cnt !== 32'h0) $display("FAIL midrst_mispred_cnt: got %0d want 0", mispred_cnt); else n_pass++;
        @(posedge clk);
        #1 clear_ex();
        @(negedge clk);
        rst_n    = 1'b1;
        exp_ctrl = 0;
        exp_mis  = 0;
        jump_to(32'h50);
        @(negedge clk);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL midrst_btb_cleared: got %b want 0", pred_taken); else n_pass++;
        jump_to(32'h80);
        @(negedge clk);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL midrst_update_dropped: got %b want 0", pred_taken); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_branch_alloc();
        test_counter_decay();
        test_counter_sat();
        test_abs_target();
        test_stall();
        test_alias();
        test_wrap();
        test_counters();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
